// File: rtl/control_panel.sv
// User-panel command encoder: button presses edit shadow registers that commit to the robot
// programming outputs with a one-cycle Confirm strobe. Optional macro: AUTOREPEAT_EN.
module control_panel #(
    parameter int DUR_MAX     = 63,
    parameter int DUR_DEFAULT = 30,
    parameter int TIME_MAX    = 1439,
    parameter int TIME_STEP   = 15
`ifdef AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4
`endif
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        BtnPower,
    input  logic        BtnNext,
    input  logic        BtnUp,
    input  logic        BtnDown,
    input  logic        BtnCancel,
    output logic        En,
    output logic [1:0]  FunctionSelect,
    output logic [5:0]  Duration,
    output logic [10:0] setTime,
    output logic        Confirm,
    output logic [2:0]  Stage,
    output logic [10:0] EditValue,
    output logic        Armed
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_SEL_FUNC = 3'd1,
        ST_SET_DUR  = 3'd2,
        ST_SET_TIME = 3'd3,
        ST_ARMED    = 3'd4
    } state_t;

    localparam logic [5:0]  DUR_MAX_V     = 6'(DUR_MAX);
    localparam logic [5:0]  DUR_DEFAULT_V = 6'(DUR_DEFAULT);
    localparam logic [11:0] TIME_MAX_V    = 12'(TIME_MAX);
    localparam logic [10:0] TIME_STEP_V   = 11'(TIME_STEP);
    localparam logic [10:0] TIME_WRAP_V   = 11'(TIME_MAX - (TIME_MAX % TIME_STEP));

    state_t      state_q, state_d;
    logic [4:0]  btn_q, btn_d;
    logic        en_q, en_d;
    logic        armed_q, armed_d;
    logic        confirm_q, confirm_d;
    logic [1:0]  func_q, func_d;
    logic [5:0]  dur_q, dur_d;
    logic [10:0] time_q, time_d;
    logic [1:0]  edit_func_q, edit_func_d;
    logic [5:0]  edit_dur_q, edit_dur_d;
    logic [10:0] edit_time_q, edit_time_d;

    logic [4:0]  btn_ev;
    logic        pwr_ev, nxt_ev, up_ev, dn_ev, can_ev;
    logic        step_up, step_dn;
    logic        in_edit;
    logic [11:0] time_sum;
    logic [1:0]  func_inc, func_dec;
    logic [5:0]  dur_inc, dur_dec;
    logic [10:0] time_inc, time_dec;
    logic [10:0] edit_value;

    // Bit order: {Cancel, Down, Up, Next, Power}.
    always_comb begin
        btn_d  = {BtnCancel, BtnDown, BtnUp, BtnNext, BtnPower};
        btn_ev = btn_d & ~btn_q;
        pwr_ev = btn_ev[0];
        nxt_ev = btn_ev[1];
        up_ev  = btn_ev[2];
        dn_ev  = btn_ev[3];
        can_ev = btn_ev[4];
        in_edit = (state_q == ST_SEL_FUNC) || (state_q == ST_SET_DUR) ||
                  (state_q == ST_SET_TIME);
    end

`ifdef AUTOREPEAT_EN
    logic [7:0] rep_cnt_q, rep_cnt_d;
    logic       rep_phase_q, rep_phase_d;
    logic       rep_fire;
    logic       held_one;
    logic [7:0] rep_cnt_next;

    // Counts cycles of a continuing single Up/Down hold; any higher-priority event clears it.
    always_comb begin
        rep_cnt_d    = '0;
        rep_phase_d  = 1'b0;
        rep_fire     = 1'b0;
        rep_cnt_next = rep_cnt_q + 8'd1;
        held_one     = (BtnUp && !BtnDown && btn_q[2] && !btn_q[3]) ||
                       (BtnDown && !BtnUp && btn_q[3] && !btn_q[2]);
        if (in_edit && held_one && !pwr_ev && !can_ev && !nxt_ev) begin
            if (!rep_phase_q) begin
                if (rep_cnt_next == 8'(REPEAT_DELAY)) begin
                    rep_fire    = 1'b1;
                    rep_phase_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_next;
                end
            end else begin
                rep_phase_d = 1'b1;
                if (rep_cnt_next == 8'(REPEAT_RATE)) begin
                    rep_fire = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_next;
                end
            end
        end
        step_up = (up_ev && !dn_ev) || (rep_fire && BtnUp);
        step_dn = (dn_ev && !up_ev) || (rep_fire && BtnDown);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end
`else
    always_comb begin
        step_up = up_ev && !dn_ev;
        step_dn = dn_ev && !up_ev;
    end
`endif

    always_comb begin
        func_inc = edit_func_q + 2'd1;
        func_dec = edit_func_q - 2'd1;
        dur_inc  = (edit_dur_q >= DUR_MAX_V) ? DUR_MAX_V : edit_dur_q + 6'd1;
        dur_dec  = (edit_dur_q <= 6'd1) ? 6'd1 : edit_dur_q - 6'd1;
        time_sum = {1'b0, edit_time_q} + {1'b0, TIME_STEP_V};
        time_inc = (time_sum > TIME_MAX_V) ? 11'd0 : time_sum[10:0];
        time_dec = (edit_time_q < TIME_STEP_V) ? TIME_WRAP_V : edit_time_q - TIME_STEP_V;
    end

    // Priority within edit states: Power > Cancel > Next > Up/Down.
    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        armed_d     = armed_q;
        confirm_d   = 1'b0;
        func_d      = func_q;
        dur_d       = dur_q;
        time_d      = time_q;
        edit_func_d = edit_func_q;
        edit_dur_d  = edit_dur_q;
        edit_time_d = edit_time_q;

        case (state_q)
            ST_OFF: begin
                if (pwr_ev) begin
                    state_d = ST_SEL_FUNC;
                    en_d    = 1'b1;
                end
            end
            ST_SEL_FUNC, ST_SET_DUR, ST_SET_TIME: begin
                if (pwr_ev) begin
                    state_d = ST_OFF;
                    en_d    = 1'b0;
                    armed_d = 1'b0;
                end else if (can_ev) begin
                    if (armed_q) begin
                        edit_func_d = func_q;
                        edit_dur_d  = dur_q;
                        edit_time_d = time_q;
                        state_d     = ST_ARMED;
                    end else begin
                        edit_func_d = 2'd0;
                        edit_dur_d  = DUR_DEFAULT_V;
                        edit_time_d = 11'd0;
                        state_d     = ST_SEL_FUNC;
                    end
                end else if (nxt_ev) begin
                    case (state_q)
                        ST_SEL_FUNC: state_d = ST_SET_DUR;
                        ST_SET_DUR:  state_d = ST_SET_TIME;
                        default: begin
                            state_d   = ST_ARMED;
                            func_d    = edit_func_q;
                            dur_d     = edit_dur_q;
                            time_d    = edit_time_q;
                            confirm_d = 1'b1;
                            armed_d   = 1'b1;
                        end
                    endcase
                end else if (step_up || step_dn) begin
                    case (state_q)
                        ST_SEL_FUNC: edit_func_d = step_up ? func_inc : func_dec;
                        ST_SET_DUR:  edit_dur_d  = step_up ? dur_inc : dur_dec;
                        default:     edit_time_d = step_up ? time_inc : time_dec;
                    endcase
                end
            end
            ST_ARMED: begin
                if (pwr_ev) begin
                    state_d = ST_OFF;
                    en_d    = 1'b0;
                    armed_d = 1'b0;
                end else if (nxt_ev) begin
                    state_d = ST_SEL_FUNC;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_OFF;
            btn_q       <= '0;
            en_q        <= 1'b0;
            armed_q     <= 1'b0;
            confirm_q   <= 1'b0;
            func_q      <= '0;
            dur_q       <= '0;
            time_q      <= '0;
            edit_func_q <= '0;
            edit_dur_q  <= DUR_DEFAULT_V;
            edit_time_q <= '0;
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_d;
            en_q        <= en_d;
            armed_q     <= armed_d;
            confirm_q   <= confirm_d;
            func_q      <= func_d;
            dur_q       <= dur_d;
            time_q      <= time_d;
            edit_func_q <= edit_func_d;
            edit_dur_q  <= edit_dur_d;
            edit_time_q <= edit_time_d;
        end
    end

    always_comb begin
        edit_value = '0;
        case (state_q)
            ST_SEL_FUNC: edit_value = {9'd0, edit_func_q};
            ST_SET_DUR:  edit_value = {5'd0, edit_dur_q};
            ST_SET_TIME: edit_value = edit_time_q;
            default:     edit_value = '0;
        endcase
    end

    assign En             = en_q;
    assign FunctionSelect = func_q;
    assign Duration       = dur_q;
    assign setTime        = time_q;
    assign Confirm        = confirm_q;
    assign Stage          = state_q;
    assign EditValue      = edit_value;
    assign Armed          = armed_q;

endmodule

// File: tb/tb_control_panel.sv
// Scoreboard bench for control_panel: stimulus pushes expected snapshots and commits,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_control_panel;

    localparam logic [4:0] PWR = 5'b00001;
    localparam logic [4:0] NXT = 5'b00010;
    localparam logic [4:0] UP  = 5'b00100;
    localparam logic [4:0] DN  = 5'b01000;
    localparam logic [4:0] CAN = 5'b10000;

    typedef struct packed {
        logic [2:0]  stage;
        logic        en;
        logic        armed;
        logic        conf;
        logic [1:0]  func;
        logic [5:0]  dur;
        logic [10:0] tim;
        logic [10:0] edit;
    } snap_t;

    typedef struct packed {
        logic [1:0]  func;
        logic [5:0]  dur;
        logic [10:0] tim;
    } commit_t;

    logic        Clock;
    logic        Reset;
    logic        BtnPower, BtnNext, BtnUp, BtnDown, BtnCancel;
    logic        En;
    logic [1:0]  FunctionSelect;
    logic [5:0]  Duration;
    logic [10:0] setTime;
    logic        Confirm;
    logic [2:0]  Stage;
    logic [10:0] EditValue;
    logic        Armed;

    snap_t   snapQ[$];
    string   nameQ[$];
    commit_t commitQ[$];
    int      total = 0;
    int      bad   = 0;

    control_panel dut (
        .Clock(Clock),
        .Reset(Reset),
        .BtnPower(BtnPower),
        .BtnNext(BtnNext),
        .BtnUp(BtnUp),
        .BtnDown(BtnDown),
        .BtnCancel(BtnCancel),
        .En(En),
        .FunctionSelect(FunctionSelect),
        .Duration(Duration),
        .setTime(setTime),
        .Confirm(Confirm),
        .Stage(Stage),
        .EditValue(EditValue),
        .Armed(Armed)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic snap_t mk(input int stage, input int en, input int armed, input int conf,
                                 input int func, input int dur, input int tim, input int edit);
        snap_t s;
        s.stage = 3'(stage);
        s.en    = 1'(en);
        s.armed = 1'(armed);
        s.conf  = 1'(conf);
        s.func  = 2'(func);
        s.dur   = 6'(dur);
        s.tim   = 11'(tim);
        s.edit  = 11'(edit);
        return s;
    endfunction

    task automatic checkOutput(input string name, input snap_t exp);
        snap_t act;
        act.stage = Stage;
        act.en    = En;
        act.armed = Armed;
        act.conf  = Confirm;
        act.func  = FunctionSelect;
        act.dur   = Duration;
        act.tim   = setTime;
        act.edit  = EditValue;
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got stage=%0d en=%0d armed=%0d confirm=%0d func=%0d dur=%0d time=%0d edit=%0d, expected stage=%0d en=%0d armed=%0d confirm=%0d func=%0d dur=%0d time=%0d edit=%0d",
                     name, act.stage, act.en, act.armed, act.conf, act.func, act.dur, act.tim, act.edit,
                     exp.stage, exp.en, exp.armed, exp.conf, exp.func, exp.dur, exp.tim, exp.edit);
        end
    endtask

    // Monitor: snapshots are checked one per negedge; every Confirm must match a queued commit.
    always @(negedge Clock) begin
        if (snapQ.size() > 0) begin
            checkOutput(nameQ.pop_front(), snapQ.pop_front());
        end
        if (Confirm === 1'b1) begin
            total++;
            if (commitQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL confirm_unexpected: got Confirm=1 func=%0d dur=%0d time=%0d, expected no Confirm",
                         FunctionSelect, Duration, setTime);
            end else begin
                commit_t c;
                c = commitQ.pop_front();
                if (FunctionSelect !== c.func || Duration !== c.dur || setTime !== c.tim) begin
                    bad++;
                    $display("[TB] FAIL commit_values: got func=%0d dur=%0d time=%0d, expected func=%0d dur=%0d time=%0d",
                             FunctionSelect, Duration, setTime, c.func, c.dur, c.tim);
                end
            end
        end
    end

    task automatic pushSnapshot(input string name, input snap_t exp);
        nameQ.push_back(name);
        snapQ.push_back(exp);
    endtask

    task automatic expectCommit(input int func, input int dur, input int tim);
        commit_t c;
        c.func = 2'(func);
        c.dur  = 6'(dur);
        c.tim  = 11'(tim);
        commitQ.push_back(c);
    endtask

    // Drive buttons for 'hold' edges, release, then queue the expected post-action snapshot.
    task automatic applyStimulus(input logic [4:0] btns, input int hold, input string name,
                                 input snap_t exp);
        {BtnCancel, BtnDown, BtnUp, BtnNext, BtnPower} = btns;
        repeat (hold) begin
            @(posedge Clock);
            #1;
        end
        {BtnCancel, BtnDown, BtnUp, BtnNext, BtnPower} = 5'b0;
        pushSnapshot(name, exp);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        {BtnCancel, BtnDown, BtnUp, BtnNext, BtnPower} = 5'b0;
        repeat (2) @(posedge Clock);
        #1;
        pushSnapshot("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock);
        #1;

        // Basic commit with default edit values
        applyStimulus(PWR, 1, "power_on",     mk(1, 1, 0, 0, 0, 0, 0, 0));
        applyStimulus(NXT, 1, "to_set_dur",   mk(2, 1, 0, 0, 0, 0, 0, 30));
        applyStimulus(NXT, 1, "to_set_time",  mk(3, 1, 0, 0, 0, 0, 0, 0));
        expectCommit(0, 30, 0);
        applyStimulus(NXT, 1, "commit_first", mk(4, 1, 1, 1, 0, 30, 0, 0));

        // Function wrap, duration saturation, time wrap
        applyStimulus(NXT, 1, "armed_to_func", mk(1, 1, 1, 0, 0, 30, 0, 0));
        applyStimulus(DN,  1, "func_wrap_dn",  mk(1, 1, 1, 0, 0, 30, 0, 3));
        applyStimulus(NXT, 1, "func_to_dur",   mk(2, 1, 1, 0, 0, 30, 0, 30));
        for (int i = 0; i < 32; i++)
            applyStimulus(UP, 1, "dur_up_ramp", mk(2, 1, 1, 0, 0, 30, 0, 31 + i));
        for (int i = 0; i < 3; i++)
            applyStimulus(UP, 1, "dur_sat_max", mk(2, 1, 1, 0, 0, 30, 0, 63));
        for (int i = 0; i < 61; i++)
            applyStimulus(DN, 1, "dur_dn_ramp", mk(2, 1, 1, 0, 0, 30, 0, 62 - i));
        for (int i = 0; i < 3; i++)
            applyStimulus(DN, 1, "dur_sat_min", mk(2, 1, 1, 0, 0, 30, 0, 1));
        applyStimulus(NXT, 1, "dur_to_time",   mk(3, 1, 1, 0, 0, 30, 0, 0));
        applyStimulus(DN,  1, "time_wrap_dn",  mk(3, 1, 1, 0, 0, 30, 0, 1425));
        applyStimulus(UP,  1, "time_wrap_up",  mk(3, 1, 1, 0, 0, 30, 0, 0));
        applyStimulus(DN,  1, "time_wrap_dn2", mk(3, 1, 1, 0, 0, 30, 0, 1425));
        applyStimulus(UP,  1, "time_wrap_up2", mk(3, 1, 1, 0, 0, 30, 0, 0));
        applyStimulus(UP,  1, "time_up_15",    mk(3, 1, 1, 0, 0, 30, 0, 15));
        applyStimulus(UP,  1, "time_up_30",    mk(3, 1, 1, 0, 0, 30, 0, 30));
        applyStimulus(DN,  1, "time_dn_15",    mk(3, 1, 1, 0, 0, 30, 0, 15));
        expectCommit(3, 1, 15);
        applyStimulus(NXT, 1, "commit_second", mk(4, 1, 1, 1, 3, 1, 15, 0));

        // Cancel after a commit and event priority
        applyStimulus(NXT,      1, "re_edit",         mk(1, 1, 1, 0, 3, 1, 15, 3));
        applyStimulus(UP,       1, "func_up_wrap",    mk(1, 1, 1, 0, 3, 1, 15, 0));
        applyStimulus(UP,       1, "func_up_1",       mk(1, 1, 1, 0, 3, 1, 15, 1));
        applyStimulus(CAN,      1, "cancel_armed",    mk(4, 1, 1, 0, 3, 1, 15, 0));
        applyStimulus(NXT,      1, "func_restored",   mk(1, 1, 1, 0, 3, 1, 15, 3));
        applyStimulus(CAN,      1, "cancel_again",    mk(4, 1, 1, 0, 3, 1, 15, 0));
        applyStimulus(CAN,      1, "cancel_in_armed", mk(4, 1, 1, 0, 3, 1, 15, 0));
        applyStimulus(NXT,      1, "re_edit2",        mk(1, 1, 1, 0, 3, 1, 15, 3));
        applyStimulus(UP | DN,  1, "up_down_both",    mk(1, 1, 1, 0, 3, 1, 15, 3));
        applyStimulus(NXT | UP, 1, "next_over_up",    mk(2, 1, 1, 0, 3, 1, 15, 1));
        applyStimulus(UP,       1, "dur_up_2",        mk(2, 1, 1, 0, 3, 1, 15, 2));
        applyStimulus(CAN | NXT,1, "cancel_over_next",mk(4, 1, 1, 0, 3, 1, 15, 0));

        // Power beats a commit; OFF ignores buttons; unarmed cancel restores defaults
        applyStimulus(NXT,       1, "p_func",         mk(1, 1, 1, 0, 3, 1, 15, 3));
        applyStimulus(NXT,       1, "p_dur_restored", mk(2, 1, 1, 0, 3, 1, 15, 1));
        applyStimulus(NXT,       1, "p_time",         mk(3, 1, 1, 0, 3, 1, 15, 15));
        applyStimulus(UP,        1, "p_time_up",      mk(3, 1, 1, 0, 3, 1, 15, 30));
        applyStimulus(PWR | NXT, 1, "power_over_commit", mk(0, 0, 0, 0, 3, 1, 15, 0));
        applyStimulus(NXT,       1, "off_ignore_next",mk(0, 0, 0, 0, 3, 1, 15, 0));
        applyStimulus(UP,        1, "off_ignore_up",  mk(0, 0, 0, 0, 3, 1, 15, 0));
        applyStimulus(PWR,       1, "power_retained", mk(1, 1, 0, 0, 3, 1, 15, 3));
        applyStimulus(UP,        5, "held_up_once",   mk(1, 1, 0, 0, 3, 1, 15, 0));
        applyStimulus(DN,        1, "func_dn_3",      mk(1, 1, 0, 0, 3, 1, 15, 3));
        applyStimulus(DN,        1, "func_dn_2",      mk(1, 1, 0, 0, 3, 1, 15, 2));
        applyStimulus(CAN,       1, "cancel_unarmed", mk(1, 1, 0, 0, 3, 1, 15, 0));
        applyStimulus(NXT,       1, "dur_default",    mk(2, 1, 0, 0, 3, 1, 15, 30));
        applyStimulus(NXT,       1, "time_default",   mk(3, 1, 0, 0, 3, 1, 15, 0));
        applyStimulus(PWR,       1, "power_off_time", mk(0, 0, 0, 0, 3, 1, 15, 0));
        applyStimulus(PWR,       1, "power_on_again", mk(1, 1, 0, 0, 3, 1, 15, 0));
        applyStimulus(NXT,       1, "dur_again",      mk(2, 1, 0, 0, 3, 1, 15, 30));
        applyStimulus(UP,        1, "dur_31",         mk(2, 1, 0, 0, 3, 1, 15, 31));

        // Asynchronous reset in the middle of a cycle
        #2;
        Reset = 1'b1;
        pushSnapshot("async_reset_mid_dur", mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        applyStimulus(PWR, 1, "post_reset_power", mk(1, 1, 0, 0, 0, 0, 0, 0));
        applyStimulus(NXT, 1, "post_reset_dur",   mk(2, 1, 0, 0, 0, 0, 0, 30));

        repeat (3) @(posedge Clock);
        #1;
        total++;
        if (commitQ.size() != 0 || snapQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL queues_drained: got commits_left=%0d snapshots_left=%0d, expected 0 and 0",
                     commitQ.size(), snapQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
